// File: rtl/pool_pkg.sv
// pool_pkg: shared accumulator width, image-size limits and FSM encoding
// for the 2x2 pooling window scheduler.
package pool_pkg;
  localparam int DATA_W_DEF = 22;
  localparam int IMG_MIN = 2;
  localparam int IMG_MAX = 1024;
  localparam int CNT_W = $clog2(IMG_MAX) + 1;
  typedef enum logic [2:0] {IDLE, FILL, PAIR, DRAIN, DONE} state_t;
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: one-row line buffer, single write port, two asynchronous read ports.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [AW-1:0]     ra1,
  output logic [DATA_W-1:0] rd1
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/pool_win_sched.sv
// pool_win_sched: buffers even rows and pairs them with odd rows to emit 2x2 windows.
// POOL_WIN_SCHED_STALL_CNT_EN enables the output-stall cycle counter on o_stall_cnt.
module pool_win_sched
  import pool_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rdy,
  output logic              o_win_vld,
  input  logic              i_win_rdy,
  output logic [DATA_W-1:0] o_win0,
  output logic [DATA_W-1:0] o_win1,
  output logic [DATA_W-1:0] o_win2,
  output logic [DATA_W-1:0] o_win3,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_stall_cnt
);
  localparam int AW = $clog2(IMG_W);
  state_t state;
  logic [CNT_W-1:0] col, row;
  logic [DATA_W-1:0] held, rd0, rd1;
  logic acc, last_col, last_row, win_load;
  assign o_rdy = (state == FILL || state == PAIR) && (!o_win_vld || i_win_rdy);
  assign acc = i_vld && o_rdy;
  assign last_col = col == CNT_W'(IMG_W - 1);
  assign last_row = row == CNT_W'(IMG_H / 2 - 1);
  assign win_load = acc && state == PAIR && col[0];
  // odd column c reads the pair buf[c-1], buf[c] from the buffered even row
  pool_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .we(acc && state == FILL),
    .wa(col[AW-1:0]),
    .wd(i_data),
    .ra0(col[AW-1:0] & ~AW'(1)),
    .rd0(rd0),
    .ra1(col[AW-1:0]),
    .rd1(rd1)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      held <= '0;
      o_win_vld <= 1'b0;
      o_win0 <= '0;
      o_win1 <= '0;
      o_win2 <= '0;
      o_win3 <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (win_load) begin
        o_win_vld <= 1'b1;
        o_win0 <= rd0;
        o_win1 <= rd1;
        o_win2 <= held;
        o_win3 <= i_data;
      end else if (i_win_rdy) o_win_vld <= 1'b0;
      case (state)
        IDLE:
          if (i_start) begin
            state <= FILL;
            col <= '0;
            row <= '0;
            o_busy <= 1'b1;
          end
        FILL, PAIR:
          if (acc) begin
            col <= last_col ? '0 : col + 1'b1;
            if (state == PAIR && !col[0]) held <= i_data;
            if (last_col) begin
              state <= state == FILL ? PAIR : (last_row ? DRAIN : FILL);
              if (state == PAIR) row <= row + 1'b1;
            end
          end
        DRAIN:
          if (!o_win_vld || i_win_rdy) begin
            state <= DONE;
            o_done <= 1'b1;
          end
        default: begin
          state <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end
`ifdef POOL_WIN_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt <= '0;
    else if (state == IDLE && i_start) stall_cnt <= '0;
    else if (o_win_vld && !i_win_rdy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pool_win_sched.sv
// tb_pool_win_sched: randomized self-checking bench for pool_win_sched (4x2 and 4x4 instances).
module tb_pool_win_sched;
  localparam int DW = 22;
  typedef logic [4*DW-1:0] win_t;
  logic clk = 0, rstn = 0, start = 0, sel = 0, i_vld = 0, i_win_rdy = 0;
  logic [DW-1:0] i_data = '0;
  logic rdy_a, vld_a, busy_a, done_a, rdy_b, vld_b, busy_b, done_b;
  logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [15:0] st_a, st_b, stall;
  logic rdy, win_vld, busy, done;
  win_t win;
  logic [DW-1:0] pix [16];
  win_t exp_q[$];
  win_t obs[$];
  int done_cnt = 0;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  pool_win_sched #(.IMG_W(4), .IMG_H(2), .DATA_W(DW)) u_a (
    .clk(clk), .rstn(rstn), .i_start(start && !sel), .i_vld(i_vld), .i_data(i_data),
    .o_rdy(rdy_a), .o_win_vld(vld_a), .i_win_rdy(i_win_rdy),
    .o_win0(a0), .o_win1(a1), .o_win2(a2), .o_win3(a3),
    .o_busy(busy_a), .o_done(done_a), .o_stall_cnt(st_a));
  pool_win_sched #(.IMG_W(4), .IMG_H(4), .DATA_W(DW)) u_b (
    .clk(clk), .rstn(rstn), .i_start(start && sel), .i_vld(i_vld), .i_data(i_data),
    .o_rdy(rdy_b), .o_win_vld(vld_b), .i_win_rdy(i_win_rdy),
    .o_win0(b0), .o_win1(b1), .o_win2(b2), .o_win3(b3),
    .o_busy(busy_b), .o_done(done_b), .o_stall_cnt(st_b));
  assign rdy = sel ? rdy_b : rdy_a;
  assign win_vld = sel ? vld_b : vld_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign stall = sel ? st_b : st_a;
  assign win = sel ? {b3, b2, b1, b0} : {a3, a2, a1, a0};
  always @(negedge clk) begin
    if (win_vld && i_win_rdy) obs.push_back(win);
    if (done) done_cnt++;
  end
  // reference: every 2x2 block of the raster image, pooled outputs in raster order
  function automatic void build_exp(input int w, input int h);
    exp_q.delete();
    for (int pr = 0; pr < h / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++)
        exp_q.push_back({pix[(2*pr+1)*w + 2*pc + 1], pix[(2*pr+1)*w + 2*pc],
                         pix[2*pr*w + 2*pc + 1], pix[2*pr*w + 2*pc]});
  endfunction
  task automatic run_frame(input int n, input int vp, input int rp, input int mid, output bit ok);
    int idx = 0, cyc = 0, base = done_cnt;
    bit acc;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (done_cnt == base && cyc < 3000) begin
      i_vld = idx < n && $urandom_range(99) < vp;
      i_data = pix[idx < n ? idx : 0];
      i_win_rdy = $urandom_range(99) < rp;
      start = mid >= 0 && idx == mid;
      @(negedge clk);
      acc = i_vld && rdy;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    i_vld = 0;
    start = 0;
    i_win_rdy = 1;
    ok = done_cnt != base;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({vld_a, vld_b, busy_a, busy_b, done_a, done_b, rdy_a, rdy_b} !== 8'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000000", {vld_a, vld_b, busy_a, busy_b, done_a, done_b, rdy_a, rdy_b});
    end
    n_cmp++;
    if ({a3, a2, a1, a0, b3, b2, b1, b0} !== '0) begin
      n_fail++; $display("FAIL reset_win got %h %h want 0", {a3, a2, a1, a0}, {b3, b2, b1, b0});
    end
    n_cmp++;
    if ({st_a, st_b} !== 32'h0) begin
      n_fail++; $display("FAIL reset_stall got %h want 0", {st_a, st_b});
    end
    rstn = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    int ob0 = obs.size(), d0 = done_cnt;
    bit ok;
    win_t got;
    sel = 0;
    for (int i = 0; i < 8; i++) pix[i] = DW'(i + 1);
    build_exp(4, 2);
    run_frame(8, 100, 100, -1, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++;
    if (obs.size() - ob0 !== 2) begin n_fail++; $display("FAIL basic_count got %0d want 2", obs.size() - ob0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = ob0 + i < obs.size() ? obs[ob0 + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL basic_win%0d got %h want %h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask
  task automatic test_stall();
    int ob0 = obs.size(), d0 = done_cnt, idx = 0, cyc = 0;
    bit acc;
    win_t got;
    logic [15:0] exp_st;
`ifdef POOL_WIN_SCHED_STALL_CNT_EN
    exp_st = 16'd5;
`else
    exp_st = 16'd0;
`endif
    sel = 0;
    for (int i = 0; i < 8; i++) pix[i] = DW'(i + 1);
    build_exp(4, 2);
    i_win_rdy = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (!win_vld && cyc < 100) begin
      i_vld = 1; i_data = pix[idx];
      @(negedge clk);
      acc = i_vld && rdy;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    n_cmp++;
    if (idx !== 6 || win !== exp_q[0]) begin
      n_fail++; $display("FAIL stall_first_win got beats=%0d win=%h want beats=6 win=%h", idx, win, exp_q[0]);
    end
    for (int k = 0; k < 5; k++) begin
      i_vld = 1; i_data = pix[idx];
      @(negedge clk);
      n_cmp++;
      if ({rdy, win_vld, win} !== {2'b01, exp_q[0]}) begin
        n_fail++; $display("FAIL stall_hold%0d got rdy=%b vld=%b win=%h want rdy=0 vld=1 win=%h", k, rdy, win_vld, win, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    i_win_rdy = 1;
    cyc = 0;
    while (done_cnt == d0 && cyc < 200) begin
      i_vld = idx < 8; i_data = pix[idx < 8 ? idx : 0];
      @(negedge clk);
      acc = i_vld && rdy;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    i_vld = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (stall !== exp_st) begin n_fail++; $display("FAIL stall_cnt got %0d want %0d", stall, exp_st); end
    n_cmp++;
    if (obs.size() - ob0 !== 2) begin n_fail++; $display("FAIL stall_count got %0d want 2", obs.size() - ob0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = ob0 + i < obs.size() ? obs[ob0 + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL stall_win%0d got %h want %h", i, got, exp_q[i]); end
    end
  endtask
  task automatic test_random();
    bit ok;
    win_t got;
    sel = 1;
    for (int f = 0; f < 3; f++) begin
      int ob0 = obs.size(), d0 = done_cnt;
      for (int i = 0; i < 16; i++) pix[i] = DW'($urandom);
      build_exp(4, 4);
      run_frame(16, 50, 50, -1, ok);
      n_cmp++;
      if (!ok || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want 1", f, done_cnt - d0); end
      n_cmp++;
      if (obs.size() - ob0 !== 4) begin n_fail++; $display("FAIL rand%0d_count got %0d want 4", f, obs.size() - ob0); end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = ob0 + i < obs.size() ? obs[ob0 + i] : 'x;
        n_cmp++;
        if (got !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_win%0d got %h want %h", f, i, got, exp_q[i]); end
      end
    end
  endtask
  task automatic test_start_ignored();
    int ob0 = obs.size(), d0 = done_cnt;
    bit ok;
    win_t got;
    sel = 1;
    for (int i = 0; i < 16; i++) pix[i] = DW'($urandom);
    build_exp(4, 4);
    run_frame(16, 70, 60, 7, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midstart_done got %0d want 1", done_cnt - d0); end
    n_cmp++;
    if (obs.size() - ob0 !== 4) begin n_fail++; $display("FAIL midstart_count got %0d want 4", obs.size() - ob0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = ob0 + i < obs.size() ? obs[ob0 + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL midstart_win%0d got %h want %h", i, got, exp_q[i]); end
    end
  endtask
  task automatic test_reset_mid();
    int ob0, d0;
    bit ok;
    win_t got;
    sel = 0;
    i_win_rdy = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 5; k++) begin
      i_vld = 1; i_data = DW'(100 + k);
      @(posedge clk); #1;
    end
    i_vld = 0;
    rstn = 0;
    #1;
    n_cmp++;
    if ({win_vld, busy, done, rdy, win, stall} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got vld=%b busy=%b done=%b rdy=%b win=%h stall=%0d want all 0", win_vld, busy, done, rdy, win, stall);
    end
    @(posedge clk); #1;
    rstn = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, rdy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle got busy=%b rdy=%b want 0 0", busy, rdy); end
    for (int i = 0; i < 8; i++) pix[i] = DW'(11 + i);
    build_exp(4, 2);
    ob0 = obs.size();
    d0 = done_cnt;
    run_frame(8, 80, 80, -1, ok);
    n_cmp++;
    if (!ok || obs.size() - ob0 !== 2) begin n_fail++; $display("FAIL rstmid_count got %0d want 2", obs.size() - ob0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = ob0 + i < obs.size() ? obs[ob0 + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_win%0d got %h want %h", i, got, exp_q[i]); end
    end
  endtask
  task automatic test_negative();
    int ob0 = obs.size();
    bit ok;
    win_t got;
    logic [DW-1:0] vals [8];
    sel = 0;
    vals = '{22'h3FFFFF, 22'h200000, 22'h000001, 22'h3FFFFE, 22'h1FFFFF, 22'h2AAAAA, 22'h355555, 22'h3FFF00};
    for (int i = 0; i < 8; i++) pix[i] = vals[i];
    build_exp(4, 2);
    run_frame(8, 100, 100, -1, ok);
    n_cmp++;
    if (!ok || obs.size() - ob0 !== 2) begin n_fail++; $display("FAIL neg_count got %0d want 2", obs.size() - ob0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = ob0 + i < obs.size() ? obs[ob0 + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL neg_win%0d got %h want %h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (stall !== 16'd0) begin n_fail++; $display("FAIL neg_stall_cleared got %0d want 0", stall); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_negative();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
